// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared widths, reset PC and FSM state encoding for the fetch stage
package ifu_fetch_pkg;

    localparam int XLEN    = 32;
    localparam int INST_DW = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;
    localparam logic [XLEN-1:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_REQ  = 2'd1,
        IFU_WAIT = 2'd2,
        IFU_HOLD = 2'd3
    } ifu_state_e;

    // Word-align a fetch address; instructions are always 4-byte aligned.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// rtl/ifu_pc_reg.sv - program counter with reset, redirect and sequential +4 update
module ifu_pc_reg
    import ifu_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            advance_i,
    // Value the PC takes at the next edge; the FSM latches this into the request
    // address whenever it enters REQ, so a same-cycle redirect or advance is seen.
    output logic [XLEN-1:0] pc_next_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Redirect wins over the sequential advance; the +4 wraps naturally at 2^32.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = align_pc(redirect_pc_i);
        end else if (advance_i) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_next_o = pc_d;

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - single-outstanding instruction fetch stage feeding decode
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INST_DW-1:0] imem_rsp_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [INST_DW-1:0] out_instr
);

    ifu_state_e         state_q;
    logic [XLEN-1:0]    req_addr_q;
    logic               drop_q;
    logic [INST_DW-1:0] instr_buf_q;
    logic [XLEN-1:0]    pc_buf_q;

    logic [XLEN-1:0]    pc_next;
    logic               out_fire;

    // A redirect in the same cycle kills the buffered instruction, so it never fires.
    assign out_fire = (state_q == IFU_HOLD) & out_ready & ~redirect_valid;

    ifu_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .advance_i        (out_fire),
        .pc_next_o        (pc_next)
    );

    // Fetch FSM: one request in flight, a drop flag for stale responses, one-entry output buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IFU_IDLE;
            req_addr_q  <= RESET_PC;
            drop_q      <= 1'b0;
            instr_buf_q <= '0;
            pc_buf_q    <= '0;
        end else begin
            case (state_q)
                IFU_IDLE: begin
                    state_q    <= IFU_REQ;
                    req_addr_q <= pc_next;
                end
                IFU_REQ: begin
                    // The request already on the bus keeps its address; its response is stale.
                    if (redirect_valid) begin
                        drop_q <= 1'b1;
                    end
                    if (imem_req_ready) begin
                        state_q <= IFU_WAIT;
                    end
                end
                IFU_WAIT: begin
                    if (imem_rsp_valid) begin
                        // The single outstanding response is consumed here either way.
                        drop_q <= 1'b0;
                        if (drop_q || redirect_valid) begin
                            state_q    <= IFU_REQ;
                            req_addr_q <= pc_next;
                        end else begin
                            instr_buf_q <= imem_rsp_data;
                            pc_buf_q    <= req_addr_q;
                            state_q     <= IFU_HOLD;
                        end
                    end else if (redirect_valid) begin
                        drop_q <= 1'b1;
                    end
                end
                IFU_HOLD: begin
                    if (redirect_valid || out_ready) begin
                        state_q    <= IFU_REQ;
                        req_addr_q <= pc_next;
                    end
                end
                default: begin
                    state_q <= IFU_IDLE;
                end
            endcase
        end
    end

    // Outputs come only from state and registers; address/payload read as zero when not valid.
    assign imem_req_valid = (state_q == IFU_REQ);
    assign imem_req_addr  = imem_req_valid ? req_addr_q : '0;
    assign out_valid      = (state_q == IFU_HOLD);
    assign out_pc         = out_valid ? pc_buf_q : '0;
    assign out_instr      = out_valid ? instr_buf_q : '0;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch with a transaction-level PC model
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int rdy_pct  = 100;
    int lat_min  = 0;
    int lat_max  = 0;
    bit late_rsp = 1'b0;

    logic [31:0] exp_pc = RST_PC;
    int          consumed  = 0;
    int          req_count = 0;
    bit          pending   = 1'b0;
    int          lat_cnt   = 0;
    logic [31:0] pend_addr = '0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr  = '0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: memory model drives the bus, reference model observes, then the edge.
    task automatic cycle();
        if (late_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end else if (pending && lat_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(pend_addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = (int'($urandom_range(99)) < rdy_pct);

        if (prev_stall && !rst) begin
            chk("req_valid_hold", {31'b0, imem_req_valid}, 32'd1);
            chk("req_addr_hold", imem_req_addr, prev_addr);
        end
        prev_stall = imem_req_valid && !imem_req_ready && !rst;
        prev_addr  = imem_req_addr;

        if (rst) begin
            exp_pc  = RST_PC;
            pending = 1'b0;
        end else begin
            if (out_valid && out_ready && !redirect_valid) begin
                chk("out_pc", out_pc, exp_pc);
                chk("out_instr", out_instr, memf(exp_pc));
                consumed++;
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
            if (pending) begin
                if (imem_rsp_valid) pending = 1'b0;
                else lat_cnt--;
            end
            if (imem_req_valid && imem_req_ready) begin
                pending   = 1'b1;
                lat_cnt   = int'($urandom_range(lat_max, lat_min));
                pend_addr = imem_req_addr;
                req_count++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 60 && !out_valid; i++) cycle();
        chk(tag, {31'b0, out_valid}, 32'd1);
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 60 && !imem_req_valid; i++) cycle();
        chk(tag, {31'b0, imem_req_valid}, 32'd1);
    endtask

    initial begin
        int c0;
        int r0;
        logic [31:0] p;
        logic [31:0] ins;

        // Reset state
        rst = 1'b1;
        cycle();
        cycle();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);

        // 1: zero-wait memory, decode always ready
        rst = 1'b0;
        out_ready = 1'b1;
        cycle();
        chk("t1_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t1_req_addr", imem_req_addr, RST_PC);
        cycle();
        chk("t1_wait_noreq", {31'b0, imem_req_valid}, 32'd0);
        chk("t1_wait_noout", {31'b0, out_valid}, 32'd0);
        cycle();
        chk("t1_out_valid", {31'b0, out_valid}, 32'd1);
        chk("t1_out_pc", out_pc, RST_PC);
        c0 = consumed;
        repeat (7) cycle();
        chk("t1_three_fetched", consumed - c0, 32'd3);
        chk("t1_next_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t1_next_req_addr", imem_req_addr, RST_PC + 32'd12);

        // 2: decode stalls in HOLD for 5 cycles
        out_ready = 1'b0;
        wait_valid("t2_valid");
        p   = out_pc;
        ins = out_instr;
        chk("t2_pc", p, RST_PC + 32'd12);
        repeat (5) begin
            cycle();
            chk("t2_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("t2_hold_pc", out_pc, p);
            chk("t2_hold_instr", out_instr, ins);
            chk("t2_hold_noreq", {31'b0, imem_req_valid}, 32'd0);
        end
        out_ready = 1'b1;
        c0 = consumed;
        cycle();
        chk("t2_fired", consumed - c0, 32'd1);
        chk("t2_next_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t2_next_req_addr", imem_req_addr, p + 32'd4);

        // 3: memory not ready for 4 cycles after reset
        out_ready = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        rdy_pct = 0;
        cycle();
        r0 = req_count;
        repeat (4) begin
            chk("t3_stall_valid", {31'b0, imem_req_valid}, 32'd1);
            chk("t3_stall_addr", imem_req_addr, RST_PC);
            cycle();
        end
        rdy_pct = 100;
        wait_valid("t3_valid");
        chk("t3_one_request", req_count - r0, 32'd1);
        chk("t3_out_pc", out_pc, RST_PC);
        out_ready = 1'b1;
        cycle();

        // 4: redirect during WAIT, 3-cycle memory latency
        lat_min = 2;
        lat_max = 2;
        cycle();
        chk("t4_in_wait", {31'b0, imem_req_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0103;
        cycle();
        redirect_valid = 1'b0;
        chk("t4_no_out", {31'b0, out_valid}, 32'd0);
        wait_req("t4_req");
        chk("t4_req_addr", imem_req_addr, 32'h8000_0100);
        out_ready = 1'b0;
        wait_valid("t4_valid");
        chk("t4_out_pc", out_pc, 32'h8000_0100);

        // 5: redirect and out_ready together in HOLD
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        out_ready      = 1'b1;
        c0 = consumed;
        cycle();
        redirect_valid = 1'b0;
        chk("t5_killed", {31'b0, out_valid}, 32'd0);
        chk("t5_no_fire", consumed - c0, 32'd0);
        chk("t5_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t5_req_addr", imem_req_addr, 32'h8000_0200);
        out_ready = 1'b0;
        wait_valid("t5_valid");
        chk("t5_out_pc", out_pc, 32'h8000_0200);
        out_ready = 1'b1;
        cycle();

        // 6: wrap at the top of the address space, then reset during WAIT
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        wait_valid("t6_valid_top");
        chk("t6_out_pc_top", out_pc, 32'hFFFF_FFFC);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        wait_valid("t6_valid_wrap");
        chk("t6_out_pc_wrap", out_pc, 32'h0000_0000);
        chk("t6_out_instr_wrap", out_instr, memf(32'h0000_0000));
        out_ready = 1'b1;
        cycle();
        lat_min = 4;
        lat_max = 4;
        wait_req("t6_req");
        cycle();
        cycle();
        chk("t6_in_wait", {31'b0, imem_req_valid}, 32'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        late_rsp = 1'b1;
        cycle();
        late_rsp = 1'b0;
        lat_min = 0;
        lat_max = 0;
        out_ready = 1'b0;
        chk("t6_late_ignored", {31'b0, out_valid}, 32'd0);
        wait_valid("t6_restart_valid");
        chk("t6_restart_pc", out_pc, RST_PC);
        chk("t6_restart_instr", out_instr, memf(RST_PC));
        out_ready = 1'b1;
        cycle();

        // Randomized traffic against the reference model
        c0 = consumed;
        rdy_pct = 70;
        lat_min = 0;
        lat_max = 3;
        for (int i = 0; i < 2000; i++) begin
            out_ready      = (int'($urandom_range(99)) < 60);
            redirect_valid = (int'($urandom_range(99)) < 4);
            redirect_pc    = $urandom;
            cycle();
        end
        redirect_valid = 1'b0;
        chk("rand_progress", {31'b0, (consumed - c0) > 50}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
